// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the 00-59 seconds counter: debounces START/MODE/CLR
// and runs the IDLE/RUN/PAUSE/ALARM machine that drives the counter and display.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FLASH_CYCLES    = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_MODE,
    input  logic       BTN_CLR,
    input  logic [3:0] ONES,
    input  logic [3:0] TENS,
    output logic       CNT_EN,
    output logic       CNT_RST,
    output logic       CNT_STYLE,
    output logic       BLANK,
    output logic [1:0] STATE
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(FLASH_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

    localparam int B_START = 0;
    localparam int B_MODE  = 1;
    localparam int B_CLR   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    level;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];
    logic [FW-1:0] flash_cnt;
    logic          nonzero_prev;
    logic          at_zero;

    assign raw     = {BTN_CLR, BTN_MODE, BTN_START};
    assign at_zero = (ONES == 4'd0) && (TENS == 4'd0);
    assign STATE   = state;

    // Each button: two-flop synchronizer, then a level must hold for
    // DEBOUNCE_CYCLES before it is accepted; only accepted rises pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Main sequencer. CLR outranks START, which outranks MODE; the zero
    // check only alarms on a nonzero-to-00 arrival while counting down.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            CNT_EN       <= 1'b0;
            CNT_RST      <= 1'b0;
            CNT_STYLE    <= 1'b1;
            BLANK        <= 1'b0;
            flash_cnt    <= '0;
            nonzero_prev <= 1'b0;
        end else begin
            nonzero_prev <= !at_zero;
            CNT_RST      <= 1'b0;
            case (state)
                IDLE: begin
                    CNT_EN    <= 1'b0;
                    BLANK     <= 1'b0;
                    flash_cnt <= '0;
                    if (press[B_CLR]) begin
                        CNT_RST <= 1'b1;
                    end else if (press[B_START]) begin
                        state  <= RUN;
                        CNT_EN <= 1'b1;
                    end else if (press[B_MODE]) begin
                        CNT_STYLE <= !CNT_STYLE;
                    end
                end
                RUN: begin
                    BLANK     <= 1'b0;
                    flash_cnt <= '0;
                    if (press[B_CLR]) begin
                        state   <= IDLE;
                        CNT_EN  <= 1'b0;
                        CNT_RST <= 1'b1;
                    end else if (press[B_START]) begin
                        state  <= PAUSE;
                        CNT_EN <= 1'b0;
                    end else if (!CNT_STYLE && nonzero_prev && at_zero) begin
                        state  <= ALARM;
                        CNT_EN <= 1'b0;
                    end
                end
                PAUSE: begin
                    BLANK     <= 1'b0;
                    flash_cnt <= '0;
                    if (press[B_CLR]) begin
                        state   <= IDLE;
                        CNT_EN  <= 1'b0;
                        CNT_RST <= 1'b1;
                    end else if (press[B_START]) begin
                        state  <= RUN;
                        CNT_EN <= 1'b1;
                    end
                end
                ALARM: begin
                    CNT_EN <= 1'b0;
                    if (press[B_CLR] || press[B_START]) begin
                        state     <= IDLE;
                        CNT_RST   <= 1'b1;
                        BLANK     <= 1'b0;
                        flash_cnt <= '0;
                    end else if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        BLANK     <= !BLANK;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce/flash periods;
// ONES/TENS are driven directly as the counter would present them.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic       cnt_en;
    logic       cnt_rst;
    logic       cnt_style;
    logic       blank;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FLASH_CYCLES(8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .BTN_START(btn_start),
        .BTN_MODE(btn_mode),
        .BTN_CLR(btn_clr),
        .ONES(ones),
        .TENS(tens),
        .CNT_EN(cnt_en),
        .CNT_RST(cnt_rst),
        .CNT_STYLE(cnt_style),
        .BLANK(blank),
        .STATE(state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise the masked buttons {clr,mode,start}; 2 sync + 4 debounce + 1 FSM edge.
    task automatic applyStimulus(input logic [2:0] mask);
        btn_start = mask[0];
        btn_mode  = mask[1];
        btn_clr   = mask[2];
        tick(7);
    endtask

    task automatic releaseButtons();
        btn_start = 1'b0;
        btn_mode  = 1'b0;
        btn_clr   = 1'b0;
        tick(1);
        checkOutput("rst_pulse_end", {7'd0, cnt_rst}, 8'd0);
        tick(7);
    endtask

    initial begin
        // reset
        tick(3);
        rst = 1'b0;
        tick(1);
        checkOutput("reset_state", {6'd0, state}, 8'd0);
        checkOutput("reset_style", {7'd0, cnt_style}, 8'd1);
        checkOutput("reset_en", {7'd0, cnt_en}, 8'd0);
        checkOutput("reset_cntrst", {7'd0, cnt_rst}, 8'd0);
        checkOutput("reset_blank", {7'd0, blank}, 8'd0);

        // bounce rejection
        for (int i = 0; i < 6; i++) begin
            btn_start = (i % 2 == 0);
            tick(2);
        end
        checkOutput("bounce_idle", {6'd0, state}, 8'd0);
        btn_start = 1'b1;
        tick(6);
        checkOutput("bounce_early", {6'd0, state}, 8'd0);
        tick(1);
        checkOutput("bounce_run", {6'd0, state}, 8'd1);
        checkOutput("bounce_en", {7'd0, cnt_en}, 8'd1);
        tick(3);
        checkOutput("bounce_single", {6'd0, state}, 8'd1);
        releaseButtons();

        // pause / resume / clear
        applyStimulus(3'b001);
        checkOutput("pause_state", {6'd0, state}, 8'd2);
        checkOutput("pause_en", {7'd0, cnt_en}, 8'd0);
        releaseButtons();
        applyStimulus(3'b001);
        checkOutput("resume_state", {6'd0, state}, 8'd1);
        checkOutput("resume_en", {7'd0, cnt_en}, 8'd1);
        releaseButtons();
        applyStimulus(3'b100);
        checkOutput("clr_pulse", {7'd0, cnt_rst}, 8'd1);
        checkOutput("clr_state", {6'd0, state}, 8'd0);
        checkOutput("clr_en", {7'd0, cnt_en}, 8'd0);
        releaseButtons();

        // direction lock
        applyStimulus(3'b010);
        checkOutput("mode_idle", {7'd0, cnt_style}, 8'd0);
        releaseButtons();
        applyStimulus(3'b001);
        checkOutput("run_at_zero", {6'd0, state}, 8'd1);
        releaseButtons();
        applyStimulus(3'b010);
        checkOutput("mode_run_style", {7'd0, cnt_style}, 8'd0);
        checkOutput("mode_run_state", {6'd0, state}, 8'd1);
        releaseButtons();
        checkOutput("zero_no_alarm", {6'd0, state}, 8'd1);

        // countdown alarm 02 -> 01 -> 00
        ones = 4'd2;
        tick(1);
        ones = 4'd1;
        tick(1);
        checkOutput("count_01", {6'd0, state}, 8'd1);
        ones = 4'd0;
        tick(1);
        checkOutput("alarm_state", {6'd0, state}, 8'd3);
        checkOutput("alarm_en", {7'd0, cnt_en}, 8'd0);
        checkOutput("alarm_blank0", {7'd0, blank}, 8'd0);
        tick(7);
        checkOutput("blank_pre8", {7'd0, blank}, 8'd0);
        tick(1);
        checkOutput("blank_at8", {7'd0, blank}, 8'd1);
        tick(7);
        checkOutput("blank_pre16", {7'd0, blank}, 8'd1);
        tick(1);
        checkOutput("blank_at16", {7'd0, blank}, 8'd0);
        tick(7);
        checkOutput("blank_pre24", {7'd0, blank}, 8'd0);
        tick(1);
        checkOutput("blank_at24", {7'd0, blank}, 8'd1);
        applyStimulus(3'b001);
        checkOutput("alarm_exit_pulse", {7'd0, cnt_rst}, 8'd1);
        checkOutput("alarm_exit_state", {6'd0, state}, 8'd0);
        checkOutput("alarm_exit_blank", {7'd0, blank}, 8'd0);
        releaseButtons();

        // enter RUN at 00, wrap to 59 and count back to 00
        applyStimulus(3'b001);
        checkOutput("run2_state", {6'd0, state}, 8'd1);
        releaseButtons();
        checkOutput("run2_no_alarm", {6'd0, state}, 8'd1);
        tens = 4'd5;
        ones = 4'd9;
        tick(1);
        ones = 4'd8;
        tick(1);
        tens = 4'd0;
        ones = 4'd1;
        tick(1);
        checkOutput("run2_at01", {6'd0, state}, 8'd1);
        ones = 4'd0;
        tick(1);
        checkOutput("run2_alarm", {6'd0, state}, 8'd3);
        applyStimulus(3'b100);
        checkOutput("run2_clr_pulse", {7'd0, cnt_rst}, 8'd1);
        checkOutput("run2_clr_state", {6'd0, state}, 8'd0);
        releaseButtons();

        // simultaneous START + CLR in RUN
        applyStimulus(3'b001);
        checkOutput("sim_run", {6'd0, state}, 8'd1);
        releaseButtons();
        applyStimulus(3'b101);
        checkOutput("sim_pulse", {7'd0, cnt_rst}, 8'd1);
        checkOutput("sim_state", {6'd0, state}, 8'd0);
        checkOutput("sim_en", {7'd0, cnt_en}, 8'd0);
        releaseButtons();
        checkOutput("sim_no_pause", {6'd0, state}, 8'd0);

        // reset while in ALARM
        applyStimulus(3'b001);
        releaseButtons();
        ones = 4'd1;
        tick(1);
        ones = 4'd0;
        tick(1);
        checkOutput("ra_alarm", {6'd0, state}, 8'd3);
        tick(8);
        checkOutput("ra_blank_on", {7'd0, blank}, 8'd1);
        rst = 1'b1;
        tick(1);
        checkOutput("ra_state", {6'd0, state}, 8'd0);
        checkOutput("ra_blank", {7'd0, blank}, 8'd0);
        checkOutput("ra_cntrst", {7'd0, cnt_rst}, 8'd0);
        checkOutput("ra_style", {7'd0, cnt_style}, 8'd1);
        rst = 1'b0;
        tick(1);
        checkOutput("ra_after_cntrst", {7'd0, cnt_rst}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
